// File: rtl/sr_cmd_gen.sv
// Command generator for the SR flop: turns two raw request lines into clean, never-overlapping s/r pulses.
// Optional SR_CMD_GEN_CONFLICT_CNT_EN adds a saturating 8-bit count of conflict pulses.
module sr_cmd_gen #(
  parameter int DB_CYCLES   = 4,
  parameter int PULSE_LEN   = 2,
  parameter int HOLD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_in,
  input  logic       clr_in,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       conflict
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
  ,
  output logic [7:0] conflict_cnt
`endif
);

  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int TMR_MAX = (PULSE_LEN > HOLD_CYCLES) ? PULSE_LEN : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SET_P, CLR_P, HOLD} state_t;

  // Index 0 is the set chain, index 1 the clear chain.
  logic [1:0]      sync1, sync2, level, level_q;
  logic [DB_W-1:0] db_cnt [2];

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic             set_pend, clr_pend, set_first;
  logic             set_req, clr_req;
  logic             serve_set, serve_clr, dispatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= {clr_in, set_in};
      sync2   <= sync1;
      level_q <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= ~level[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign set_req = level[0] & ~level_q[0];
  assign clr_req = level[1] & ~level_q[1];

  // The end of HOLD dispatches directly so the gap between commands is exactly HOLD_CYCLES.
  always_comb begin
    serve_set = set_pend & (~clr_pend | set_first);
    serve_clr = clr_pend & ~serve_set;
    dispatch  = (state == IDLE) || ((state == HOLD) && (tmr == HOLD_LAST));
  end

  assign busy = (state != IDLE) | set_pend | clr_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      s         <= 1'b0;
      r         <= 1'b0;
      set_pend  <= 1'b0;
      clr_pend  <= 1'b0;
      set_first <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      conflict <= set_req & clr_req;
      if (set_req && !clr_req) begin
        set_pend <= 1'b1;
        if (!set_pend) set_first <= ~clr_pend;
      end
      if (clr_req && !set_req) begin
        clr_pend <= 1'b1;
        if (!clr_pend) set_first <= set_pend;
      end
      if (dispatch && serve_set) begin
        state    <= SET_P;
        set_pend <= 1'b0;
        tmr      <= '0;
        s        <= 1'b1;
        r        <= 1'b0;
      end else if (dispatch && serve_clr) begin
        state    <= CLR_P;
        clr_pend <= 1'b0;
        tmr      <= '0;
        s        <= 1'b0;
        r        <= 1'b1;
      end else begin
        case (state)
          SET_P, CLR_P: begin
            if (tmr == PULSE_LAST) begin
              state <= HOLD;
              tmr   <= '0;
              s     <= 1'b0;
              r     <= 1'b0;
            end else begin
              tmr <= tmr + TMR_W'(1);
            end
          end
          HOLD: begin
            if (tmr == HOLD_LAST) begin
              state <= IDLE;
              tmr   <= '0;
            end else begin
              tmr <= tmr + TMR_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            s     <= 1'b0;
            r     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed, table-driven bench for sr_cmd_gen with default parameters (DB=4, PULSE=2, HOLD=3).
// Honors SR_CMD_GEN_CONFLICT_CNT_EN when the design is built with it.
module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_in = 1'b0;
  logic clr_in = 1'b0;
  logic s, r, busy, conflict;
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  sr_cmd_gen dut (
    .clk(clk),
    .rst_n(rst_n),
    .set_in(set_in),
    .clr_in(clr_in),
    .s(s),
    .r(r),
    .busy(busy),
    .conflict(conflict)
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Cycle indices count rising edges after reset release; len 0 means never.
  typedef struct {
    int set_start;
    int set_len;
    int clr_start;
    int clr_len;
    int s_first;
    int s_len;
    int r_first;
    int r_len;
    int busy_on;
    int busy_off;
    int conf_at;
  } vec_t;

  localparam int NVEC = 6;
  localparam int WIN  = 32;

  vec_t vecs [NVEC];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    rst_n  = 1'b0;
    set_in = 1'b0;
    clr_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int s_err = 0, r_err = 0, b_err = 0, c_err = 0, overlap = 0;
    bit es, er, eb, ec;
    resetDut();
    for (int k = 0; k < WIN; k++) begin
      set_in = (v.set_len > 0) && (k >= v.set_start) && (k < v.set_start + v.set_len);
      clr_in = (v.clr_len > 0) && (k >= v.clr_start) && (k < v.clr_start + v.clr_len);
      @(posedge clk);
      #1;
      es = (v.s_len > 0) && (k >= v.s_first) && (k < v.s_first + v.s_len);
      er = (v.r_len > 0) && (k >= v.r_first) && (k < v.r_first + v.r_len);
      eb = (k >= v.busy_on) && (k < v.busy_off);
      ec = (k == v.conf_at);
      if (s !== es) s_err++;
      if (r !== er) r_err++;
      if (busy !== eb) b_err++;
      if (conflict !== ec) c_err++;
      if (s && r) overlap++;
      @(negedge clk);
    end
    checkOutput($sformatf("v%0d_s_window_errs", idx), s_err, 0);
    checkOutput($sformatf("v%0d_r_window_errs", idx), r_err, 0);
    checkOutput($sformatf("v%0d_busy_window_errs", idx), b_err, 0);
    checkOutput($sformatf("v%0d_conflict_errs", idx), c_err, 0);
    checkOutput($sformatf("v%0d_s_and_r_cycles", idx), overlap, 0);
`ifdef SR_CMD_GEN_CONFLICT_CNT_EN
    checkOutput($sformatf("v%0d_conflict_cnt", idx), int'(conflict_cnt), (v.conf_at >= 0) ? 1 : 0);
`endif
  endtask

  initial begin
    int bad;
    bit seen;

    //            set_st len clr_st len s_1st len r_1st len busy_on off conf
    vecs[0] = '{2, 12, 0, 0,  9, 2,  0, 0,  8, 14, -1};
    vecs[1] = '{0, 0,  3, 12, 0, 0, 10, 2,  9, 15, -1};
    vecs[2] = '{2, 3,  0, 0,  0, 0,  0, 0,  0, 0,  -1};
    vecs[3] = '{2, 10, 2, 10, 0, 0,  0, 0,  0, 0,   8};
    vecs[4] = '{4, 8,  2, 8, 14, 2,  9, 2,  8, 19, -1};
    vecs[5] = '{2, 8,  5, 8,  9, 2, 14, 2,  8, 19, -1};

    // Reset held with set_in high: every output must stay low.
    rst_n  = 1'b0;
    set_in = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (s || r || busy || conflict) bad++;
    end
    checkOutput("reset_outputs_high_cycles", bad, 0);
    @(negedge clk);
    set_in = 1'b0;
    rst_n  = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (s || r || busy) bad++;
    end
    checkOutput("after_reset_spurious_cycles", bad, 0);
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

    // Reset asserted between edges during the second SET_P cycle.
    resetDut();
    set_in = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (s) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("midop_s_seen", int'(seen), 1);
    @(posedge clk);
    #1;
    checkOutput("midop_s_second_cycle", int'(s), 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midop_s_async_drop", int'(s), 0);
    checkOutput("midop_busy_async_drop", int'(busy), 0);
    set_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (s || r || busy) bad++;
    end
    checkOutput("midop_no_pulse_after_release", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
